// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for the register bank: grants the single C port to ALU, load or debug,
// filters illegal selectors, and tracks pending loads to stall dependent operand reads.
module regbank_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 6,
   parameter int NREG   = 35
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              alu_we,
   input  logic [SEL_W-1:0]  alu_sel,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   input  logic [SEL_W-1:0]  ld_sel,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              dbg_valid,
   input  logic [SEL_W-1:0]  dbg_sel,
   input  logic [DATA_W-1:0] dbg_data,
   output logic              dbg_ready,
   input  logic              ld_issue,
   input  logic [SEL_W-1:0]  ld_issue_sel,
   input  logic [4:0]        rd_sel_a,
   input  logic [SEL_W-1:0]  rd_sel_b,
   output logic              stall,
   output logic              wr_en,
   output logic [SEL_W-1:0]  Sel_C,
   output logic [DATA_W-1:0] Data_C,
   output logic              illegal_wr,
   output logic [7:0]        err_cnt
);

   // state     | meaning
   // LAST_LD   | load port won the most recent ld/dbg grant; debug wins the next tie
   // LAST_DBG  | debug port won the most recent grant (reset); load wins the next tie
   typedef enum logic {LAST_LD = 1'b0, LAST_DBG = 1'b1} last_t;

   localparam logic [SEL_W-1:0] NREG_SEL = SEL_W'(NREG);

   last_t             last_grant, last_grant_nxt;
   logic              grant_ld, grant_dbg;
   logic              wr_req, wr_legal;
   logic [SEL_W-1:0]  wr_sel;
   logic [DATA_W-1:0] wr_data;
   logic [NREG-1:0]   pending, pending_nxt;
   logic              clr_v;
   logic [SEL_W-1:0]  clr_sel;
   logic [SEL_W-1:0]  rd_a_ext;
   logic              pend_a, pend_b;

   function automatic logic sel_legal(input logic [SEL_W-1:0] s);
      return (s <= SEL_W'(27)) || (s == SEL_W'(30)) || (s == SEL_W'(31)) || (s == SEL_W'(34));
   endfunction

   always_ff @(posedge clk) begin
      if (reset) last_grant <= LAST_DBG;
      else       last_grant <= last_grant_nxt;
   end

   always_comb begin
      grant_ld       = 1'b0;
      grant_dbg      = 1'b0;
      last_grant_nxt = last_grant;
      if (ld_valid && dbg_valid) begin
         grant_ld  = (last_grant == LAST_DBG);
         grant_dbg = ~grant_ld;
      end else begin
         grant_ld  = ld_valid;
         grant_dbg = dbg_valid;
      end
      ld_ready  = ~reset & ~alu_we & grant_ld;
      dbg_ready = ~reset & ~alu_we & grant_dbg;
      if (ld_ready)       last_grant_nxt = LAST_LD;
      else if (dbg_ready) last_grant_nxt = LAST_DBG;
   end

   always_comb begin
      wr_req  = 1'b0;
      wr_sel  = '0;
      wr_data = '0;
      if (alu_we) begin
         wr_req  = 1'b1;
         wr_sel  = alu_sel;
         wr_data = alu_data;
      end else if (ld_ready) begin
         wr_req  = 1'b1;
         wr_sel  = ld_sel;
         wr_data = ld_data;
      end else if (dbg_ready) begin
         wr_req  = 1'b1;
         wr_sel  = dbg_sel;
         wr_data = dbg_data;
      end
      wr_legal = sel_legal(wr_sel);
   end

   // Clear lands one edge after Data_C is driven; a same-cycle issue re-sets the bit.
   always_comb begin
      pending_nxt = pending;
      if (clr_v && (clr_sel < NREG_SEL))
         pending_nxt[clr_sel] = 1'b0;
      if (ld_issue && (ld_issue_sel < NREG_SEL))
         pending_nxt[ld_issue_sel] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en      <= 1'b0;
         Sel_C      <= '0;
         Data_C     <= '0;
         illegal_wr <= 1'b0;
         err_cnt    <= '0;
         pending    <= '0;
         clr_v      <= 1'b0;
         clr_sel    <= '0;
      end else begin
         wr_en      <= wr_req & wr_legal;
         illegal_wr <= wr_req & ~wr_legal;
         if (wr_req && wr_legal) begin
            Sel_C  <= wr_sel;
            Data_C <= wr_data;
         end
         if (wr_req && !wr_legal && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
         clr_v   <= ld_ready;
         clr_sel <= ld_sel;
         pending <= pending_nxt;
      end
   end

   assign rd_a_ext = SEL_W'(rd_sel_a);
   assign pend_a   = (rd_a_ext < NREG_SEL) ? pending[rd_a_ext] : 1'b0;
   assign pend_b   = (rd_sel_b < NREG_SEL) ? pending[rd_sel_b] : 1'b0;
   assign stall    = pend_a | pend_b;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench for regbank_write_arbiter: directed scenarios plus random traffic, all
// compared cycle by cycle against a behavioural model of grants, writes and pending loads.
module tb_regbank_write_arbiter;
   localparam int DATA_W = 16;
   localparam int SEL_W  = 6;
   localparam int NREG   = 35;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic              alu_we;
   logic [SEL_W-1:0]  alu_sel;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic [SEL_W-1:0]  ld_sel;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              dbg_valid;
   logic [SEL_W-1:0]  dbg_sel;
   logic [DATA_W-1:0] dbg_data;
   logic              dbg_ready;
   logic              ld_issue;
   logic [SEL_W-1:0]  ld_issue_sel;
   logic [4:0]        rd_sel_a;
   logic [SEL_W-1:0]  rd_sel_b;
   logic              stall;
   logic              wr_en;
   logic [SEL_W-1:0]  Sel_C;
   logic [DATA_W-1:0] Data_C;
   logic              illegal_wr;
   logic [7:0]        err_cnt;

   regbank_write_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .NREG(NREG)) dut (
      .clk(clk), .reset(reset),
      .alu_we(alu_we), .alu_sel(alu_sel), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_data(ld_data), .ld_ready(ld_ready),
      .dbg_valid(dbg_valid), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
      .ld_issue(ld_issue), .ld_issue_sel(ld_issue_sel),
      .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .stall(stall),
      .wr_en(wr_en), .Sel_C(Sel_C), .Data_C(Data_C),
      .illegal_wr(illegal_wr), .err_cnt(err_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model
   typedef struct {int due; int sel;} clr_t;
   clr_t clr_q[$];
   bit   m_pend[NREG];
   bit   m_prefer_ld;
   bit   m_wr_en, m_ill;
   int   m_sel_c, m_data_c, m_err;
   int   cyc;
   bit   last_ldr, last_dbgr;
   logic s_ld_ready, s_dbg_ready, s_stall, s_wr_en, s_illegal;
   logic [SEL_W-1:0]  s_sel_c;
   logic [DATA_W-1:0] s_data_c;
   logic [7:0]        s_err;

   function automatic bit legal(input int s);
      return (s >= 0 && s <= 27) || s == 30 || s == 31 || s == 34;
   endfunction

   function automatic bit pend_at(input int s);
      return (s < NREG) ? m_pend[s] : 1'b0;
   endfunction

   task automatic model_reset();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      clr_q.delete();
      m_prefer_ld = 1'b1;
      m_wr_en = 0; m_ill = 0; m_sel_c = 0; m_data_c = 0; m_err = 0;
   endtask

   task automatic run_cycle();
      bit e_ldr, e_dbgr;
      bit has_wr;
      int w_sel, w_data;
      clr_t keep[$];
      @(negedge clk);
      e_ldr = 0; e_dbgr = 0;
      if (!reset && !alu_we) begin
         if (ld_valid && dbg_valid) begin
            e_ldr  = m_prefer_ld;
            e_dbgr = !m_prefer_ld;
         end else begin
            e_ldr  = ld_valid;
            e_dbgr = dbg_valid;
         end
      end
      s_ld_ready = ld_ready; s_dbg_ready = dbg_ready; s_stall = stall;
      s_wr_en = wr_en; s_sel_c = Sel_C; s_data_c = Data_C; s_illegal = illegal_wr; s_err = err_cnt;
      check("ld_ready", ld_ready, e_ldr);
      check("dbg_ready", dbg_ready, e_dbgr);
      check("stall", stall, pend_at(int'(rd_sel_a)) | pend_at(int'(rd_sel_b)));
      check("wr_en", wr_en, m_wr_en);
      check("Sel_C", Sel_C, m_sel_c);
      check("Data_C", Data_C, m_data_c);
      check("illegal_wr", illegal_wr, m_ill);
      check("err_cnt", err_cnt, m_err);
      if (reset) begin
         model_reset();
      end else begin
         has_wr = 1; w_sel = 0; w_data = 0;
         if (alu_we)      begin w_sel = alu_sel; w_data = alu_data; end
         else if (e_ldr)  begin w_sel = ld_sel;  w_data = ld_data;  end
         else if (e_dbgr) begin w_sel = dbg_sel; w_data = dbg_data; end
         else has_wr = 0;
         if (e_ldr)  m_prefer_ld = 0;
         if (e_dbgr) m_prefer_ld = 1;
         m_wr_en = 0; m_ill = 0;
         if (has_wr && legal(w_sel)) begin
            m_wr_en = 1; m_sel_c = w_sel; m_data_c = w_data;
         end else if (has_wr) begin
            m_ill = 1;
            if (m_err < 255) m_err++;
         end
         foreach (clr_q[i]) begin
            if (clr_q[i].due == cyc) begin
               if (clr_q[i].sel < NREG) m_pend[clr_q[i].sel] = 1'b0;
            end else keep.push_back(clr_q[i]);
         end
         clr_q = keep;
         if (e_ldr) clr_q.push_back('{due: cyc + 1, sel: int'(ld_sel)});
         if (ld_issue && ld_issue_sel < NREG) m_pend[ld_issue_sel] = 1'b1;
      end
      last_ldr = e_ldr; last_dbgr = e_dbgr;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_we = 0; alu_sel = '0; alu_data = '0;
      ld_valid = 0; ld_sel = '0; ld_data = '0;
      dbg_valid = 0; dbg_sel = '0; dbg_data = '0;
      ld_issue = 0; ld_issue_sel = '0; rd_sel_a = '0; rd_sel_b = '0;
   endtask

   initial begin
      cyc = 0;
      idle_inputs();
      reset = 1;
      @(posedge clk);
      #1;
      model_reset();
      // reset held with requests present: nothing accepted
      ld_valid = 1; dbg_valid = 1; alu_we = 1;
      run_cycle();
      check("rst_ld_ready", s_ld_ready, 0);
      check("rst_wr_en", s_wr_en, 0);

      // single load return
      reset = 0; idle_inputs();
      ld_valid = 1; ld_sel = 5; ld_data = 16'h1234;
      run_cycle();
      check("ld1_ready", s_ld_ready, 1);
      idle_inputs();
      run_cycle();
      check("ld1_wr_en", s_wr_en, 1);
      check("ld1_sel", s_sel_c, 5);
      check("ld1_data", s_data_c, 16'h1234);

      // ALU blocks both ports, then round robin ld, dbg, ld
      reset = 1; run_cycle(); reset = 0;
      alu_we = 1; alu_sel = 34; alu_data = 16'hBEEF;
      ld_valid = 1; ld_sel = 10; ld_data = 16'h0A0A;
      dbg_valid = 1; dbg_sel = 11; dbg_data = 16'h0B0B;
      for (int i = 0; i < 3; i++) run_cycle();
      alu_we = 0;
      run_cycle();
      check("rr0_ld", s_ld_ready, 1);
      check("alu_sel34", s_sel_c, 34);
      run_cycle();
      check("rr1_dbg", s_dbg_ready, 1);
      run_cycle();
      check("rr2_ld", s_ld_ready, 1);
      idle_inputs();
      run_cycle();

      // illegal debug writes and counter saturation
      reset = 1; run_cycle(); reset = 0;
      dbg_valid = 1; dbg_sel = 28; dbg_data = 16'h1111;
      run_cycle();
      dbg_sel = 33;
      run_cycle();
      check("ill_pulse1", s_illegal, 1);
      idle_inputs();
      run_cycle();
      check("ill_pulse2", s_illegal, 1);
      check("ill_cnt2", s_err, 2);
      check("ill_no_wr", s_wr_en, 0);
      dbg_valid = 1; dbg_sel = 40;
      for (int i = 0; i < 300; i++) run_cycle();
      idle_inputs();
      run_cycle();
      check("err_sat", s_err, 255);

      // pending load stall window
      ld_issue = 1; ld_issue_sel = 7;
      run_cycle();
      ld_issue = 0; rd_sel_a = 7;
      run_cycle();
      check("stall_issued", s_stall, 1);
      ld_valid = 1; ld_sel = 7; ld_data = 16'h7777;
      run_cycle();
      check("stall_n", s_stall, 1);
      ld_valid = 0;
      run_cycle();
      check("stall_n1", s_stall, 1);
      run_cycle();
      check("stall_n2", s_stall, 0);

      // set wins over same-cycle clear
      idle_inputs();
      ld_issue = 1; ld_issue_sel = 9;
      run_cycle();
      ld_issue = 0; ld_valid = 1; ld_sel = 9; ld_data = 16'h9999;
      run_cycle();
      ld_valid = 0; ld_issue = 1; ld_issue_sel = 9;
      run_cycle();
      ld_issue = 0; rd_sel_b = 9;
      run_cycle();
      check("set_wins", s_stall, 1);
      run_cycle();
      check("set_wins2", s_stall, 1);

      // reset right after a grant
      alu_we = 1; alu_sel = 3; alu_data = 16'h3333;
      run_cycle();
      alu_we = 0; reset = 1;
      run_cycle();
      reset = 0;
      run_cycle();
      check("rst_mid_wr", s_wr_en, 0);
      check("rst_mid_err", s_err, 0);
      check("rst_mid_stall", s_stall, 0);

      // random traffic
      idle_inputs();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         alu_we = ($urandom_range(0, 99) < 30);
         alu_sel = SEL_W'($urandom_range(0, 40));
         alu_data = DATA_W'($urandom);
         if (!ld_valid || last_ldr || reset) begin
            ld_valid = ($urandom_range(0, 99) < 60);
            ld_sel = SEL_W'($urandom_range(0, 40));
            ld_data = DATA_W'($urandom);
         end
         if (!dbg_valid || last_dbgr || reset) begin
            dbg_valid = ($urandom_range(0, 99) < 50);
            dbg_sel = SEL_W'($urandom_range(0, 63));
            dbg_data = DATA_W'($urandom);
         end
         ld_issue = ($urandom_range(0, 99) < 35);
         ld_issue_sel = SEL_W'($urandom_range(0, 40));
         rd_sel_a = 5'($urandom);
         rd_sel_b = SEL_W'($urandom_range(0, 40));
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Sequencer and write-port arbiter for the 35-entry register bank, which has a single C write port. Each cycle it grants that port to at most one of three sources: the ALU writeback, the memory-load return and the debug/loader port. It drives the registered Sel_C/Data_C write to the bank and filters writes aimed at read-only or unmapped selectors. It also keeps a pending-load scoreboard and raises a decode stall when an A/B operand read targets a register whose load has not yet landed.

## Interface
- DATA_W, 16, data width of all write sources and Data_C
- SEL_W, 6, width of C/B selectors
- NREG, 35, scoreboard depth (selectors 0..34)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alu_we  in  1  ALU writeback request; never stalled
- alu_sel  in  SEL_W  ALU destination selector
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  memory-load return valid
- ld_sel  in  SEL_W  load destination selector
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load return accepted this cycle
- dbg_valid  in  1  debug/loader write valid
- dbg_sel  in  SEL_W  debug destination selector
- dbg_data  in  DATA_W  debug data
- dbg_ready  out  1  debug write accepted this cycle
- ld_issue  in  1  a load was issued this cycle
- ld_issue_sel  in  SEL_W  destination of the issued load
- rd_sel_a  in  5  decode operand A selector
- rd_sel_b  in  SEL_W  decode operand B selector
- stall  out  1  operand hazard on pending load (combinational)
- wr_en  out  1  bank write strobe (registered)
- Sel_C  out  SEL_W  bank write selector (registered)
- Data_C  out  DATA_W  bank write data (registered)
- illegal_wr  out  1  one-cycle pulse: accepted write to illegal selector
- err_cnt  out  8  saturating count of illegal writes

## Operation
- Legal write selectors: 0..27, 30, 31, 34. Illegal: 28, 29 (input ports), 32, 33 and 35..63.
- Grant priority: alu_we first. The load and debug ports are served only when alu_we=0.
- Load vs debug is round-robin via a last_grant register. When both are valid, grant the port not granted last. When only one is valid, grant it. last_grant updates on every ld or dbg grant.
- ld_ready = ~alu_we & ld_valid & grant_ld. dbg_ready is the same form. A transfer completes when valid and ready are both high in the same cycle.
- A granted write with a legal selector registers wr_en=1, Sel_C=sel, Data_C=data.
- A granted write with an illegal selector is still accepted (ready=1), but:
  - wr_en=0 next cycle, and Sel_C/Data_C hold their previous values;
  - illegal_wr=1 for one cycle;
  - err_cnt increments and saturates at 255.
- No grant: wr_en=0 next cycle; Sel_C/Data_C hold.
- Scoreboard: 35 pending bits.
  - ld_issue sets pending[ld_issue_sel]. Selectors ≥35 are ignored.
  - An accepted load write clears its bit on the edge after its Data_C cycle, i.e. two edges after acceptance, so the bank holds the value before the stall drops.
  - Set and clear of the same bit in one cycle: set wins.
  - Re-issue to an already-pending register: the bit stays set.
  - ALU and debug writes never touch the scoreboard.
- stall = pending[rd_sel_a] | pending[rd_sel_b], where an out-of-range selector reads as 0.

## Timing
- Reset (synchronous): wr_en=0, Sel_C=0, Data_C=0, illegal_wr=0, err_cnt=0, all pending bits=0, last_grant=dbg (so the load port wins the first tie). stall=0 after reset. ld_ready/dbg_ready=0 while reset=1.
- Latency: grant cycle N drives wr_en/Sel_C/Data_C in cycle N+1. The bank captures the write at the end of N+1.
- Throughput: one write per cycle, with no bubble between back-to-back grants.
- The ready signals are combinational from the valid signals and alu_we, with no registered handshake. Sources hold sel/data stable until ready.
- Reset asserted mid-operation discards the in-flight registered write (wr_en=0 next cycle) and clears all pending loads. Source handshakes in progress are dropped, and sources must re-present.

## Test plan
- Reset, then ld_valid=1 sel=5 data=0x1234 with alu_we=0 → ld_ready=1 that cycle; next cycle wr_en=1, Sel_C=5, Data_C=0x1234.
- alu_we=1 sel=34 data=0xBEEF while ld and dbg are both valid for 3 cycles → ld_ready=dbg_ready=0 throughout; 3 consecutive writes to 34. Then with ALU idle, grants go ld, dbg, ld.
- dbg write to sel=28, then sel=33 → dbg_ready=1 each time, wr_en=0, illegal_wr pulses twice, err_cnt=2. After 300 illegal writes, err_cnt=255.
- ld_issue sel=7, then rd_sel_a=7 → stall=1. Load return to 7 accepted at cycle N → stall=1 through N+1, stall=0 from N+2.
- Same cycle: ld_issue sel=9 and clear of pending[9] → pending[9] stays set, stall stays 1 for rd_sel_b=9.
- Assert reset the cycle after a grant of sel=3 → wr_en=0, pending=0, err_cnt=0 the next cycle.
